xadc_capture: RTL and testbench

Acquisition stage between the XADC DRP port and the VGA trace renderer. Reads one auxiliary channel on every end-of-conversion, decimates, optionally waits for a rising-edge trigger, and fills one bank of a ping-pong sample memory. The other bank holds a stable frame that the renderer reads by screen column, already scaled to a pixel row. Banks swap only on a renderer-supplied frame boundary, so a frame is never torn.

---
 rtl/voltmeter_pkg.sv | 21 ++
 rtl/xadc_capture_pingpong_ram.sv | 31 +++
 rtl/xadc_capture.sv | 176 +++++++++++++++++
 tb/tb_xadc_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/voltmeter_pkg.sv
// Shared types and screen/ADC constants for the XADC capture path.
package voltmeter_pkg;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned ADC_BITS   = 12;
    localparam logic [6:0]  VAUX6_ADDR = 7'h16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FILL  = 2'd2,
        FULL  = 2'd3
    } cap_state_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_WAIT = 1'b1
    } drp_state_t;

endpackage

// File: rtl/xadc_capture_pingpong_ram.sv
// Two-bank simple dual-port sample RAM: writes go to the back bank, reads to the front bank.
module pingpong_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 12
) (
    input  logic          clk,
    input  logic          bank,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    localparam int unsigned IW = $clog2(2 * DEPTH);

    logic [DW-1:0] mem [0:2*DEPTH-1];
    logic [IW-1:0] w_idx;
    logic [IW-1:0] r_idx;

    // Bank b occupies entries b*DEPTH .. b*DEPTH+DEPTH-1.
    assign w_idx = IW'(wa) + (bank ? IW'(0) : IW'(DEPTH));
    assign r_idx = IW'(ra) + (bank ? IW'(DEPTH) : IW'(0));

    always_ff @(posedge clk) begin
        if (we) mem[w_idx] <= wd;
        rd <= mem[r_idx];
    end

endmodule

// File: rtl/xadc_capture.sv
// XADC DRP reader, decimator, capture FSM and scaled ping-pong frame readout.
// Optional rising-edge trigger: define XADC_CAPTURE_TRIGGER_EN.
module xadc_capture
    import voltmeter_pkg::*;
#(
    parameter int unsigned DEPTH     = SCREEN_W,
    parameter logic [6:0]  CHAN_ADDR = VAUX6_ADDR,
    parameter int unsigned DECIM     = 1,
    parameter int unsigned ROWS      = SCREEN_H
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eoc,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    input  logic        run,
    input  logic [11:0] trig_level,
    input  logic        swap,
    input  logic [9:0]  rd_addr,
    output logic [8:0]  rd_row,
    output logic        frame_valid,
    output logic [1:0]  state,
    output logic [7:0]  overrun_cnt
);

    drp_state_t   d_st;
    cap_state_t   cap_st;
    logic [11:0]  sample;
    logic         smp_vld;
    logic [7:0]   dec_cnt;
    logic         dec_vld;
    logic         trig;
    logic [9:0]   wr_ptr;
    logic         bank;
    logic         we;
    logic [9:0]   wa;
    logic [11:0]  rd_smp;
    logic [20:0]  prod;

    assign drp_daddr = CHAN_ADDR;
    assign state     = cap_st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_st        <= D_IDLE;
            drp_den     <= 1'b0;
            sample      <= '0;
            smp_vld     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            drp_den <= 1'b0;
            smp_vld <= 1'b0;
            case (d_st)
                D_IDLE: if (eoc) begin
                    drp_den <= 1'b1;
                    d_st    <= D_WAIT;
                end
                D_WAIT: begin
                    if (drp_drdy) begin
                        sample  <= drp_do[15:4];
                        smp_vld <= 1'b1;
                        d_st    <= D_IDLE;
                    end
                    if (eoc && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 8'd1;
                end
                default: d_st <= D_IDLE;
            endcase
        end
    end

    assign dec_vld = smp_vld && (dec_cnt == '0);

`ifdef XADC_CAPTURE_TRIGGER_EN
    logic [11:0] prev;
    logic        prev_vld;

    assign trig = prev_vld && (prev < trig_level) && (sample >= trig_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            prev_vld <= 1'b0;
        end else if ((cap_st == FULL && swap && run) || (cap_st == IDLE && run)) begin
            prev_vld <= 1'b0;
        end else if (cap_st == ARMED && dec_vld) begin
            prev     <= sample;
            prev_vld <= 1'b1;
        end
    end
`else
    logic unused_trig;
    assign unused_trig = ^trig_level;
    assign trig        = 1'b1;
`endif

    assign we = run && dec_vld && ((cap_st == ARMED && trig) || cap_st == FILL);
    assign wa = (cap_st == ARMED) ? '0 : wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_st      <= IDLE;
            wr_ptr      <= '0;
            bank        <= 1'b0;
            frame_valid <= 1'b0;
            dec_cnt     <= '0;
        end else begin
            if (smp_vld) dec_cnt <= (dec_cnt == 8'(DECIM - 1)) ? '0 : dec_cnt + 8'd1;
            case (cap_st)
                IDLE: begin
                    wr_ptr <= '0;
                    if (run) begin
                        cap_st  <= ARMED;
                        dec_cnt <= '0;
                    end
                end
                ARMED: begin
                    if (!run) begin
                        cap_st <= IDLE;
                        wr_ptr <= '0;
                    end else if (dec_vld && trig) begin
                        cap_st <= (DEPTH == 1) ? FULL : FILL;
                        wr_ptr <= 10'd1;
                    end
                end
                FILL: begin
                    if (!run) begin
                        cap_st <= IDLE;
                        wr_ptr <= '0;
                    end else if (dec_vld) begin
                        if (wr_ptr == 10'(DEPTH - 1)) cap_st <= FULL;
                        else wr_ptr <= wr_ptr + 10'd1;
                    end
                end
                FULL: begin
                    if (swap) begin
                        bank        <= ~bank;
                        frame_valid <= 1'b1;
                        wr_ptr      <= '0;
                        if (run) begin
                            cap_st  <= ARMED;
                            dec_cnt <= '0;
                        end else begin
                            cap_st <= IDLE;
                        end
                    end
                end
                default: cap_st <= IDLE;
            endcase
        end
    end

    pingpong_ram #(
        .DEPTH (DEPTH),
        .AW    (10),
        .DW    (ADC_BITS)
    ) u_ram (
        .clk  (clk),
        .bank (bank),
        .we   (we),
        .wa   (wa),
        .wd   (sample),
        .ra   (rd_addr),
        .rd   (rd_smp)
    );

    assign prod = 21'(rd_smp) * 21'(ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_row <= 9'(ROWS - 1);
        else if (frame_valid) rd_row <= 9'(ROWS - 1) - 9'(prod >> ADC_BITS);
        else rd_row <= 9'(ROWS - 1);
    end

endmodule

// File: tb/tb_xadc_capture.sv
// Directed bench for xadc_capture (DECIM=2) with a bench-side DRP responder task.
module tb_xadc_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eoc = 1'b0;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        drp_drdy = 1'b0;
    logic [15:0] drp_do = '0;
    logic        run = 1'b0;
    logic [11:0] trig_level = '0;
    logic        swap = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [8:0]  rd_row;
    logic        frame_valid;
    logic [1:0]  state;
    logic [7:0]  overrun_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    int den_cnt = 0;
    int den_base;

    xadc_capture #(
        .DEPTH     (640),
        .CHAN_ADDR (7'h16),
        .DECIM     (2),
        .ROWS      (480)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .eoc         (eoc),
        .drp_den     (drp_den),
        .drp_daddr   (drp_daddr),
        .drp_drdy    (drp_drdy),
        .drp_do      (drp_do),
        .run         (run),
        .trig_level  (trig_level),
        .swap        (swap),
        .rd_addr     (rd_addr),
        .rd_row      (rd_row),
        .frame_valid (frame_valid),
        .state       (state),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (drp_den === 1'b1) den_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One conversion: eoc, then drdy three cycles after drp_den, then one cycle for the write.
    task automatic conv(input logic [11:0] code);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        tick();
        drp_drdy = 1'b1;
        drp_do   = {code, 4'h0};
        tick();
        drp_drdy = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_den", drp_den, 0);
        check("rst_daddr", drp_daddr, 7'h16);
        check("rst_row", rd_row, 479);
        check("rst_fvalid", frame_valid, 0);
        check("rst_state", state, 0);
        check("rst_overrun", overrun_cnt, 0);
        rst_n = 1'b1;
        tick();

        // DRP handshake
        den_base = den_cnt;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("hs_den", drp_den, 1);
        check("hs_daddr", drp_daddr, 7'h16);
        tick();
        tick();
        drp_drdy = 1'b1;
        drp_do   = 16'hABC0;
        tick();
        drp_drdy = 1'b0;
        tick();
        check("hs_den_count", den_cnt - den_base, 1);
        check("hs_sample", dut.sample, 12'hABC);

        // Overrun: eoc held through the first D_WAIT cycle
        den_base = den_cnt;
        eoc = 1'b1;
        tick();
        tick();
        eoc = 1'b0;
        tick();
        drp_drdy = 1'b1;
        drp_do   = 16'h1230;
        tick();
        drp_drdy = 1'b0;
        tick();
        check("ovr_cnt", overrun_cnt, 1);
        check("ovr_den_count", den_cnt - den_base, 1);

`ifndef XADC_CAPTURE_TRIGGER_EN
        // Free-run fill with ramp 0,1,2..: index j holds code 2j
        run = 1'b1;
        tick();
        check("fill_armed", state, 1);
        conv(12'd0);
        check("fill_state", state, 2);
        for (int i = 1; i < 1280; i++) conv(12'(i));
        check("fill_full", state, 3);
        rd_addr = 10'd5;
        tick();
        tick();
        check("fill_masked_row", rd_row, 479);
        check("fill_fvalid_pre", frame_valid, 0);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        tick();
        tick();
        check("swap_fvalid", frame_valid, 1);
        check("swap_state", state, 1);
        check("swap_row5", rd_row, 478);
        rd_addr = 10'd639;
        tick();
        tick();
        check("swap_row639", rd_row, 330);
        rd_addr = 10'd100;
        tick();
        rd_addr = 10'd200;
        tick();
        check("pipe_row100", rd_row, 456);
        tick();
        check("pipe_row200", rd_row, 433);

        // swap outside FULL must not change the display bank
        rd_addr = 10'd5;
        swap = 1'b1;
        tick();
        swap = 1'b0;
        tick();
        tick();
        check("swap_ign_row", rd_row, 478);
        check("swap_ign_state", state, 1);

        // Second frame: decimated samples 0, 2048, 4095, then filler
        for (int k = 0; k < 1280; k++) begin
            if (k % 2 == 1) conv(12'hFFF);
            else if (k == 0) conv(12'd0);
            else if (k == 2) conv(12'd2048);
            else if (k == 4) conv(12'd4095);
            else conv(12'd7);
        end
        check("frame2_full", state, 3);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        rd_addr = 10'd0;
        tick();
        rd_addr = 10'd1;
        tick();
        check("scale_code0", rd_row, 479);
        rd_addr = 10'd2;
        tick();
        check("scale_code2048", rd_row, 239);
        tick();
        check("scale_code4095", rd_row, 0);

        // Abort mid-FILL
        for (int k = 0; k < 10; k++) conv(12'd100);
        check("abort_fill", state, 2);
        run = 1'b0;
        tick();
        check("abort_idle", state, 0);
        rd_addr = 10'd1;
        tick();
        tick();
        check("abort_row", rd_row, 239);
        check("abort_fvalid", frame_valid, 1);
`else
        // Trigger at 2048: decimated 2100, 2200 (no crossing), 2000, 2100 (crossing)
        trig_level = 12'd2048;
        run = 1'b1;
        tick();
        conv(12'd2100);
        conv(12'd0);
        conv(12'd2200);
        conv(12'd0);
        check("trig_no_cross", state, 1);
        conv(12'd2000);
        conv(12'd0);
        check("trig_below", state, 1);
        conv(12'd2100);
        check("trig_fill", state, 2);
        check("trig_idx0", dut.u_ram.mem[640], 2100);
`endif

        // Asynchronous reset mid-FILL
        run = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) conv(12'd50);
        check("rst2_fill", state, 2);
        rst_n = 1'b0;
        #1;
        check("rst2_state", state, 0);
        check("rst2_fvalid", frame_valid, 0);
        check("rst2_row", rd_row, 479);
        check("rst2_overrun", overrun_cnt, 0);
        check("rst2_den", drp_den, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
